// File: rtl/mem_align_seq_pkg.sv
// mem_align_seq_pkg
// Shared encodings for the memory alignment sequencer: the data RAM stage
// store/load opcodes, the sequencer FSM states and a helper that gives the
// index of the last byte touched by an access.
// Ports: none (package).
package mem_align_seq_pkg;

  typedef enum logic [1:0] {
    ST_SB   = 2'b00,
    ST_SH   = 2'b01,
    ST_SW   = 2'b10,
    ST_NONE = 2'b11
  } store_op_e;

  typedef enum logic [2:0] {
    LD_LB   = 3'b000,
    LD_LH   = 3'b001,
    LD_LW   = 3'b010,
    LD_LBU  = 3'b011,
    LD_LHU  = 3'b100,
    LD_NONE = 3'b111
  } load_op_e;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SPLIT = 1'b1
  } state_e;

  // Only the five architectural load codes count as loads; anything else
  // behaves like "no load".
  function automatic logic load_known(input logic [2:0] ld);
    case (ld)
      LD_LB, LD_LH, LD_LW, LD_LBU, LD_LHU: load_known = 1'b1;
      default:                             load_known = 1'b0;
    endcase
  endfunction

  // Access size minus one (0 byte, 1 halfword, 3 word).
  function automatic logic [1:0] last_byte_idx(input logic       is_store,
                                               input logic [1:0] st,
                                               input logic [2:0] ld);
    if (is_store) begin
      case (st)
        ST_SH:   last_byte_idx = 2'd1;
        ST_SW:   last_byte_idx = 2'd3;
        default: last_byte_idx = 2'd0;
      endcase
    end else begin
      case (ld)
        LD_LH, LD_LHU: last_byte_idx = 2'd1;
        LD_LW:         last_byte_idx = 2'd3;
        default:       last_byte_idx = 2'd0;
      endcase
    end
  endfunction

endpackage

// File: rtl/mem_align_ext.sv
// mem_align_ext
// Combinational final assembly of a split load: drops the last byte read
// into its little-endian slot of the accumulator and applies the sign or
// zero extension that the original load opcode asks for.
// Ports:
//   acc_data  in  32  bytes gathered in earlier split cycles (others zero)
//   last_byte in  8   byte returned by the RAM in the final cycle
//   byte_idx  in  2   slot of last_byte
//   load_op   in  3   original load opcode
//   data      out 32  writeback value
module mem_align_ext
  import mem_align_seq_pkg::*;
(
  input  logic [31:0] acc_data,
  input  logic [7:0]  last_byte,
  input  logic [1:0]  byte_idx,
  input  logic [2:0]  load_op,
  output logic [31:0] data
);

  logic [31:0] assembled;

  always_comb begin
    assembled = acc_data;
    assembled[{byte_idx, 3'b000} +: 8] = last_byte;
    case (load_op)
      LD_LB:   data = {{24{assembled[7]}}, assembled[7:0]};
      LD_LH:   data = {{16{assembled[15]}}, assembled[15:0]};
      LD_LBU:  data = {24'h0, assembled[7:0]};
      LD_LHU:  data = {16'h0, assembled[15:0]};
      default: data = assembled;
    endcase
  end

endmodule

// File: rtl/mem_align_seq.sv
// mem_align_seq
// Sits between the execute stage and the data RAM stage. Aligned accesses
// pass straight through with no added latency. Misaligned halfword/word
// accesses are split into byte accesses (SB / LBU) at consecutive addresses,
// one per cycle, stalling the upstream pipeline until the last byte.
// Build option: define MISALIGN_TRAP_EN to flag misaligned accesses on
// misalign_trap instead of splitting them.
// Ports:
//   CLK, RST                 clock, synchronous active-high reset
//   req_valid/addr/wdata     memory op from execute stage
//   req_store/req_load       op encodings (11 / 111 = none)
//   ram_addr/wdata/store/load  drive to the data RAM stage
//   ram_rdata                load result from the data RAM stage
//   stall                    freeze upstream while a split is in flight
//   rsp_valid/rsp_data       load writeback
//   misalign_trap            misaligned access flag (trap build only)
module mem_align_seq
  import mem_align_seq_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic        req_valid,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_store,
  input  logic [2:0]  req_load,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  output logic [1:0]  ram_store,
  output logic [2:0]  ram_load,
  input  logic [31:0] ram_rdata,
  output logic        stall,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        misalign_trap
);

  state_e      state;
  logic [1:0]  byte_cnt;
  logic [1:0]  last_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        store_q;
  logic [2:0]  load_q;
  logic [31:0] acc;

  logic        is_store;
  logic        is_load;
  logic        is_op;
  logic        misaligned;
  logic [1:0]  last_idx;
  logic [2:0]  span;
  logic [31:0] ext_data;

  // An access is misaligned when its last byte falls into the next word;
  // a store takes priority over a simultaneous load.
  always_comb begin
    is_store   = (req_store != ST_NONE);
    is_load    = !is_store && load_known(req_load);
    is_op      = req_valid && (is_store || is_load);
    last_idx   = last_byte_idx(is_store, req_store, req_load);
    span       = {1'b0, req_addr[1:0]} + {1'b0, last_idx};
    misaligned = is_op && span[2];
  end

  mem_align_ext u_ext (
    .acc_data  (acc),
    .last_byte (ram_rdata[7:0]),
    .byte_idx  (byte_cnt),
    .load_op   (load_q),
    .data      (ext_data)
  );

  // RAM-side and response outputs. In IDLE the request drives the RAM
  // directly (byte 0 of a split is issued here too); in SPLIT the captured
  // request plus byte counter drives it. Reset forces a quiet interface.
  always_comb begin
    ram_addr      = req_addr;
    ram_wdata     = req_wdata;
    ram_store     = ST_NONE;
    ram_load      = LD_NONE;
    stall         = 1'b0;
    rsp_valid     = 1'b0;
    rsp_data      = ram_rdata;
    misalign_trap = 1'b0;

    if (state == S_IDLE) begin
      if (is_op && !misaligned) begin
        ram_store = is_store ? req_store : ST_NONE;
        ram_load  = is_store ? LD_NONE : req_load;
        rsp_valid = is_load;
      end else if (misaligned) begin
`ifdef MISALIGN_TRAP_EN
        misalign_trap = 1'b1;
`else
        ram_wdata = {24'h0, req_wdata[7:0]};
        ram_store = is_store ? ST_SB : ST_NONE;
        ram_load  = is_store ? LD_NONE : LD_LBU;
        stall     = 1'b1;
`endif
      end
    end else begin
      ram_addr  = addr_q + {30'h0, byte_cnt};
      ram_wdata = {24'h0, wdata_q[{byte_cnt, 3'b000} +: 8]};
      ram_store = store_q ? ST_SB : ST_NONE;
      ram_load  = store_q ? LD_NONE : LD_LBU;
      stall     = (byte_cnt != last_q);
      if (byte_cnt == last_q && !store_q) begin
        rsp_valid = 1'b1;
        rsp_data  = ext_data;
      end
    end

    if (RST) begin
      ram_wdata     = 32'h0;
      ram_store     = ST_NONE;
      ram_load      = LD_NONE;
      stall         = 1'b0;
      rsp_valid     = 1'b0;
      misalign_trap = 1'b0;
    end
  end

  // Split sequencer. Byte 0 is consumed in the acceptance cycle, so the
  // counter starts at 1 on entry to SPLIT; the accumulator is cleared on
  // exit so the next split starts from zero in its upper bytes.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= S_IDLE;
      byte_cnt <= 2'd0;
      acc      <= 32'h0;
      last_q   <= 2'd0;
      addr_q   <= 32'h0;
      wdata_q  <= 32'h0;
      store_q  <= 1'b0;
      load_q   <= LD_NONE;
    end else begin
      case (state)
        S_IDLE: begin
`ifndef MISALIGN_TRAP_EN
          if (misaligned) begin
            state    <= S_SPLIT;
            byte_cnt <= 2'd1;
            last_q   <= last_idx;
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
            store_q  <= is_store;
            load_q   <= req_load;
            acc      <= {24'h0, ram_rdata[7:0]};
          end
`endif
        end
        S_SPLIT: begin
          acc[{byte_cnt, 3'b000} +: 8] <= ram_rdata[7:0];
          if (byte_cnt == last_q) begin
            state    <= S_IDLE;
            byte_cnt <= 2'd0;
            acc      <= 32'h0;
          end else begin
            byte_cnt <= byte_cnt + 2'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_align_seq.sv
// tb_mem_align_seq
// Self-checking bench for mem_align_seq. A byte-addressed RAM behaves as the
// data RAM stage; a separate reference memory is updated from whole-access
// semantics (little-endian, wrap-around addressing, store wins over load)
// and supplies every expected value.
module tb_mem_align_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_store;
  logic [2:0]  req_load;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [1:0]  ram_store;
  logic [2:0]  ram_load;
  logic [31:0] ram_rdata;
  logic        stall;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        misalign_trap;

  logic [7:0]  ram     [0:4095];
  logic [7:0]  ref_mem [0:4095];
  logic        loadPreset;

  int nAsserts = 0;
  int nFails   = 0;

`ifdef MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  always #5 clk = ~clk;

  mem_align_seq dut (
    .CLK           (clk),
    .RST           (rst),
    .req_valid     (req_valid),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .req_store     (req_store),
    .req_load      (req_load),
    .ram_addr      (ram_addr),
    .ram_wdata     (ram_wdata),
    .ram_store     (ram_store),
    .ram_load      (ram_load),
    .ram_rdata     (ram_rdata),
    .stall         (stall),
    .rsp_valid     (rsp_valid),
    .rsp_data      (rsp_data),
    .misalign_trap (misalign_trap)
  );

  // Data RAM stage: combinational read with load extension.
  always_comb begin
    logic [31:0] w;
    w = {ram[ram_addr[11:0] + 12'd3], ram[ram_addr[11:0] + 12'd2],
         ram[ram_addr[11:0] + 12'd1], ram[ram_addr[11:0]]};
    case (ram_load)
      3'b000:  ram_rdata = {{24{w[7]}}, w[7:0]};
      3'b001:  ram_rdata = {{16{w[15]}}, w[15:0]};
      3'b011:  ram_rdata = {24'h0, w[7:0]};
      3'b100:  ram_rdata = {16'h0, w[15:0]};
      default: ram_rdata = w;
    endcase
  end

  // Data RAM stage: write on the clock edge.
  always @(posedge clk) begin
    if (loadPreset) begin
      for (int i = 0; i < 4096; i++) ram[i] <= ref_mem[i];
    end else if (ram_store != 2'b11) begin
      for (int i = 0; i < 4; i++)
        if (i < (ram_store == 2'b00 ? 1 : ram_store == 2'b01 ? 2 : 4))
          ram[ram_addr[11:0] + 12'(i)] <= ram_wdata[8*i +: 8];
    end
  end

  function automatic int accessBytes(input bit isSt, input logic [1:0] st, input logic [2:0] ld);
    if (isSt) return (st == 2'b00) ? 1 : (st == 2'b01) ? 2 : 4;
    return (ld == 3'b010) ? 4 : (ld == 3'b001 || ld == 3'b100) ? 2 : 1;
  endfunction

  function automatic logic [31:0] refLoad(input logic [31:0] a, input logic [2:0] ld);
    logic [31:0] v;
    logic [31:0] ai;
    int n;
    v = 32'h0;
    n = accessBytes(1'b0, 2'b11, ld);
    for (int i = 0; i < n; i++) begin
      ai = a + 32'(i);
      v[8*i +: 8] = ref_mem[ai[11:0]];
    end
    case (ld)
      3'b000:  v = {{24{v[7]}}, v[7:0]};
      3'b001:  v = {{16{v[15]}}, v[15:0]};
      default: v = v;
    endcase
    return v;
  endfunction

  task automatic applyStimulus(input logic v, input logic [31:0] a, input logic [31:0] wd,
                               input logic [1:0] st, input logic [2:0] ld);
    req_valid = v;
    req_addr  = a;
    req_wdata = wd;
    req_store = st;
    req_load  = ld;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAsserts++;
    assert (obs === exp)
    else begin
      nFails++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic checkWord(input string tag, input logic [31:0] a, input logic [31:0] exp);
    checkOutput(tag, {ram[a[11:0] + 12'd3], ram[a[11:0] + 12'd2],
                      ram[a[11:0] + 12'd1], ram[a[11:0]]}, exp);
  endtask

  // One complete access: hold the request for as many cycles as the access
  // should take, checking handshake and RAM-side behaviour each cycle, then
  // return to idle and update the reference memory for stores.
  task automatic runOp(input logic [31:0] a, input logic [31:0] wd, input logic [1:0] st,
                       input logic [2:0] ld, output logic [31:0] got);
    bit isSt, isLd, mis, split, trapped;
    int n, cycles;
    logic [31:0] exp, ai;
    isSt    = (st != 2'b11);
    isLd    = !isSt && (ld inside {3'b000, 3'b001, 3'b010, 3'b011, 3'b100});
    n       = accessBytes(isSt, st, ld);
    mis     = (isSt || isLd) && ((int'(a[1:0]) + n - 1) > 3);
    split   = mis && !TRAP;
    trapped = mis && TRAP;
    cycles  = split ? n : 1;
    exp     = refLoad(a, ld);
    got     = 32'h0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      applyStimulus(1'b1, a, wd, st, ld);
      #1;
      checkOutput("stall", {31'h0, stall}, {31'h0, c < cycles - 1});
      checkOutput("rsp_valid", {31'h0, rsp_valid}, {31'h0, isLd && !trapped && c == cycles - 1});
      checkOutput("misalign_trap", {31'h0, misalign_trap}, {31'h0, trapped});
      if (isLd && !trapped && c == cycles - 1) begin
        checkOutput("rsp_data", rsp_data, exp);
        got = rsp_data;
      end
      if (split) begin
        checkOutput("split_addr", ram_addr, a + 32'(c));
        checkOutput("split_store", {30'h0, ram_store}, isSt ? 32'h0 : 32'h3);
        checkOutput("split_load", {29'h0, ram_load}, isSt ? 32'h7 : 32'h3);
        if (isSt) checkOutput("split_wbyte", {24'h0, ram_wdata[7:0]}, {24'h0, wd[8*c +: 8]});
      end
      if (trapped) begin
        checkOutput("trap_store", {30'h0, ram_store}, 32'h3);
        checkOutput("trap_load", {29'h0, ram_load}, 32'h7);
      end
    end
    if (isSt && !trapped) begin
      for (int i = 0; i < n; i++) begin
        ai = a + 32'(i);
        ref_mem[ai[11:0]] = wd[8*i +: 8];
      end
    end
    @(negedge clk);
    applyStimulus(1'b0, a, wd, 2'b11, 3'b111);
    #1;
    checkOutput("idle_stall", {31'h0, stall}, 32'h0);
    if (isSt) begin
      for (int i = 0; i < 4; i++) begin
        ai = a + 32'(i);
        checkOutput("mem_byte", {24'h0, ram[ai[11:0]]}, {24'h0, ref_mem[ai[11:0]]});
      end
    end
  endtask

  initial begin
    logic [31:0] got;
    logic [31:0] a;
    logic [1:0]  st;
    logic [2:0]  ld;
    int          diffs;
    logic [2:0]  ldCodes [0:5];
    ldCodes = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b111};

    for (int i = 0; i < 4096; i++) ref_mem[i] = 8'($urandom);
    {ref_mem['h103], ref_mem['h102], ref_mem['h101], ref_mem['h100]} = 32'h44332211;
    {ref_mem['h107], ref_mem['h106], ref_mem['h105], ref_mem['h104]} = 32'h887766A5;

    // Reset with a live store request: the RAM interface must stay quiet.
    rst        = 1'b1;
    loadPreset = 1'b1;
    applyStimulus(1'b1, 32'h100, 32'hFFFFFFFF, 2'b10, 3'b111);
    #1;
    checkOutput("rst_stall", {31'h0, stall}, 32'h0);
    checkOutput("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    checkOutput("rst_trap", {31'h0, misalign_trap}, 32'h0);
    checkOutput("rst_ram_store", {30'h0, ram_store}, 32'h3);
    checkOutput("rst_ram_load", {29'h0, ram_load}, 32'h7);
    checkOutput("rst_ram_wdata", ram_wdata, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst        = 1'b0;
    loadPreset = 1'b0;
    applyStimulus(1'b0, 32'h100, 32'h0, 2'b11, 3'b111);
    #1;
    checkOutput("idle_ram_addr", ram_addr, 32'h100);
    checkOutput("idle_ram_store", {30'h0, ram_store}, 32'h3);
    checkWord("preset_100", 32'h100, 32'h44332211);

    $display("[TB] directed accesses");
    runOp(32'h100, 32'h0, 2'b11, 3'b010, got);
    checkOutput("lw_100", got, 32'h44332211);
`ifndef MISALIGN_TRAP_EN
    runOp(32'h103, 32'h0, 2'b11, 3'b010, got);
    checkOutput("lw_103", got, 32'h7766A544);
    runOp(32'h103, 32'h0, 2'b11, 3'b001, got);
    checkOutput("lh_103", got, 32'hFFFFA544);
    runOp(32'h103, 32'h0, 2'b11, 3'b100, got);
    checkOutput("lhu_103", got, 32'h0000A544);
`endif

    // Reset in the second cycle of a split load, then an aligned load must
    // be served immediately (the sequencer is back in IDLE).
    @(negedge clk);
    applyStimulus(1'b1, 32'h101, 32'h12345678, 2'b11, 3'b010);
    #1;
    checkOutput("mid_first_stall", {31'h0, stall}, {31'h0, !TRAP});
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_stall", {31'h0, stall}, 32'h0);
    checkOutput("mid_rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    checkOutput("mid_rst_wdata", ram_wdata, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(1'b1, 32'h100, 32'h0, 2'b11, 3'b010);
    #1;
    checkOutput("post_rst_stall", {31'h0, stall}, 32'h0);
    checkOutput("post_rst_rsp_valid", {31'h0, rsp_valid}, 32'h1);
    checkOutput("post_rst_data", rsp_data, refLoad(32'h100, 3'b010));
    @(negedge clk);
    applyStimulus(1'b0, 32'h0, 32'h0, 2'b11, 3'b111);

`ifndef MISALIGN_TRAP_EN
    runOp(32'h102, 32'hDEADBEEF, 2'b10, 3'b111, got);
    checkWord("sw_102_lo", 32'h100, 32'hBEEF2211);
    checkWord("sw_102_hi", 32'h104, 32'h8877DEAD);
`else
    runOp(32'h103, 32'h00001234, 2'b01, 3'b111, got);
    checkWord("trap_sh_lo", 32'h100, 32'h44332211);
    checkWord("trap_sh_hi", 32'h104, 32'h887766A5);
`endif

    // Wrap-around at the top of the address space, and store-over-load.
    runOp(32'hFFFFFFFF, 32'hCAFEF00D, 2'b10, 3'b111, got);
    runOp(32'hFFFFFFFF, 32'h0, 2'b11, 3'b010, got);
    runOp(32'hFFFFFFFE, 32'h0, 2'b11, 3'b001, got);
    runOp(32'h110, 32'h0BADC0DE, 2'b10, 3'b010, got);
    runOp(32'h10D, 32'h5A5AA5A5, 2'b01, 3'b000, got);

    $display("[TB] random accesses");
    for (int k = 0; k < 80; k++) begin
      a  = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFF8 + 32'($urandom_range(0, 7))
                                       : 32'h100 + 32'($urandom_range(0, 63));
      st = $urandom_range(0, 1) ? 2'b11 : 2'($urandom_range(0, 3));
      ld = ldCodes[$urandom_range(0, 5)];
      runOp(a, $urandom, st, ld, got);
    end

    diffs = 0;
    for (int i = 0; i < 4096; i++) if (ram[i] !== ref_mem[i]) diffs++;
    checkOutput("mem_window_diffs", 32'(diffs), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

endmodule
